work_dispatch: RTL and testbench

Host-side counterpart of the miner's serial link.
- Transmit path: accepts one 512-bit work unit (midstate + data2), serializes it as 64 bytes through a byte-level bitbang transmitter, MSB byte first, matching the miner's shift-left receive order.
- Receive path: assembles 4-byte golden-nonce replies from a byte-level bitbang receiver into 32-bit words.
- Sits on a controller FPGA or test harness that feeds one miner board.

---
 rtl/work_link_pkg.sv | 14 +
 rtl/work_dispatch_if.sv | 31 +++
 rtl/nonce_assembler.sv | 56 +++++
 rtl/work_dispatch.sv | 83 ++++++++
 tb/tb_work_dispatch.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/work_link_pkg.sv
// work_link_pkg: shared sizes and TX state encoding for the host-side miner link.
package work_link_pkg;
    localparam int WORK_BYTES  = 64;
    localparam int NONCE_BYTES = 4;
    localparam int WORK_W      = 512;
    typedef enum logic [2:0] {
        TX_IDLE      = 3'd0,
        TX_LOAD      = 3'd1,
        TX_WAIT_FREE = 3'd2,
        TX_START     = 3'd3,
        TX_GAP       = 3'd4,
        TX_DRAIN     = 3'd5
    } tx_state_t;
endpackage

// File: rtl/work_dispatch_if.sv
// work_dispatch_if: host link bundle.
// Work handshake (work_valid/work_ready, midstate, data2), byte transmitter
// (tx_start, tx_data, tx_busy), byte receiver (rx_data_ready, rx_data), and
// status (nonce_valid, nonce, rx_timeout, work_sent, sent_count, nonce_count).
interface work_dispatch_if import work_link_pkg::*; #(parameter int CNT_W = 16);
    logic                  work_valid;
    logic                  work_ready;
    logic [WORK_W/2-1:0]   midstate;
    logic [WORK_W/2-1:0]   data2;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_busy;
    logic                  rx_data_ready;
    logic [7:0]            rx_data;
    logic                  nonce_valid;
    logic [31:0]           nonce;
    logic                  rx_timeout;
    logic                  work_sent;
    logic [CNT_W-1:0]      sent_count;
    logic [CNT_W-1:0]      nonce_count;
    modport slave (
        input  work_valid, midstate, data2, tx_busy, rx_data_ready, rx_data,
        output work_ready, tx_start, tx_data, nonce_valid, nonce, rx_timeout,
               work_sent, sent_count, nonce_count
    );
    modport master (
        output work_valid, midstate, data2, tx_busy, rx_data_ready, rx_data,
        input  work_ready, tx_start, tx_data, nonce_valid, nonce, rx_timeout,
               work_sent, sent_count, nonce_count
    );
endinterface

// File: rtl/nonce_assembler.sv
// nonce_assembler: packs received bytes into 32-bit nonces, dropping stale partials.
// Ports: clk, reset_n (sync, active low); rx_data_ready/rx_data byte strobe in;
// nonce_valid pulse, nonce (held), rx_timeout pulse, nonce_count (wraps) out.
module nonce_assembler import work_link_pkg::*; #(
    parameter int RX_TIMEOUT = 1000000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_data_ready,
    input  logic [7:0]       rx_data,
    output logic             nonce_valid,
    output logic [31:0]      nonce,
    output logic             rx_timeout,
    output logic [CNT_W-1:0] nonce_count
);
    localparam int IW = $clog2(RX_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(RX_TIMEOUT - 1);
    logic [31:0]   shift;
    logic [1:0]    byte_cnt;
    logic [IW-1:0] idle_cnt;
    logic          last_byte;
    assign last_byte = rx_data_ready && byte_cnt == 2'(NONCE_BYTES - 1);
    // byte_cnt wraps 3->0 on the 4th byte, so a byte in the nonce_valid cycle starts a fresh nonce
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift       <= '0;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            nonce_valid <= 1'b0;
            nonce       <= '0;
            rx_timeout  <= 1'b0;
            nonce_count <= '0;
        end else begin
            nonce_valid <= last_byte;
            rx_timeout  <= 1'b0;
            if (rx_data_ready) begin
                shift    <= {shift[23:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
                idle_cnt <= '0;
            end else if (byte_cnt == 2'd0) begin
                idle_cnt <= '0;
            end else if (idle_cnt == IDLE_LAST) begin
                byte_cnt   <= '0;
                idle_cnt   <= '0;
                rx_timeout <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (last_byte) begin
                nonce       <= {shift[23:0], rx_data};
                nonce_count <= nonce_count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/work_dispatch.sv
// work_dispatch: serializes 512-bit work units to a byte transmitter and collects nonce replies.
// Ports: clk, reset_n (sync, active low), bus (work_dispatch_if.slave) carrying the
// work handshake, transmitter byte link, receiver byte link and status/counters.
module work_dispatch import work_link_pkg::*; #(
    parameter int START_GAP  = 2,
    parameter int RX_TIMEOUT = 1000000,
    parameter int CNT_W      = 16
) (
    input logic            clk,
    input logic            reset_n,
    work_dispatch_if.slave bus
);
    localparam int GW = START_GAP > 1 ? $clog2(START_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(START_GAP - 1);
    tx_state_t         state, next_state;
    logic [WORK_W-1:0] work_buf;
    logic [6:0]        byte_idx;
    logic [GW-1:0]     gap_cnt;
    logic              tx_start, work_sent, accept, drain_free, pkt_done;
    logic [7:0]        tx_data;
    logic [CNT_W-1:0]  sent_count;
    assign bus.work_ready = reset_n && state == TX_IDLE;
    assign accept         = bus.work_valid && bus.work_ready;
    assign drain_free     = state == TX_DRAIN && !bus.tx_busy;
    assign pkt_done       = drain_free && byte_idx == 7'(WORK_BYTES);
    assign bus.tx_start   = tx_start;
    assign bus.tx_data    = tx_data;
    assign bus.work_sent  = work_sent;
    assign bus.sent_count = sent_count;
    always_ff @(posedge clk) begin
        if (!reset_n) state <= TX_IDLE;
        else          state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            TX_IDLE:      next_state = accept ? TX_LOAD : TX_IDLE;
            TX_LOAD:      next_state = TX_WAIT_FREE;
            TX_WAIT_FREE: next_state = bus.tx_busy ? TX_WAIT_FREE : TX_START;
            TX_START:     next_state = TX_GAP;
            // the gap masks tx_busy while the transmitter is still raising it
            TX_GAP:       next_state = gap_cnt == GAP_LAST ? TX_DRAIN : TX_GAP;
            TX_DRAIN:     next_state = !drain_free ? TX_DRAIN : pkt_done ? TX_IDLE : TX_START;
            default:      next_state = TX_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            work_buf   <= '0;
            byte_idx   <= '0;
            gap_cnt    <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            work_sent  <= 1'b0;
            sent_count <= '0;
        end else begin
            tx_start  <= state == TX_START;
            work_sent <= pkt_done;
            if (accept) begin
                work_buf <= {bus.midstate, bus.data2};
                byte_idx <= '0;
            end
            if (state == TX_START) begin
                tx_data  <= work_buf[WORK_W-1 -: 8];
                work_buf <= work_buf << 8;
                byte_idx <= byte_idx + 7'd1;
                gap_cnt  <= '0;
            end
            if (state == TX_GAP) gap_cnt <= gap_cnt + 1'b1;
            if (pkt_done) sent_count <= sent_count + 1'b1;
        end
    end
    nonce_assembler #(.RX_TIMEOUT(RX_TIMEOUT), .CNT_W(CNT_W)) u_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data_ready(bus.rx_data_ready),
        .rx_data      (bus.rx_data),
        .nonce_valid  (bus.nonce_valid),
        .nonce        (bus.nonce),
        .rx_timeout   (bus.rx_timeout),
        .nonce_count  (bus.nonce_count)
    );
endmodule

// File: tb/tb_work_dispatch.sv
// tb_work_dispatch: directed self-checking bench for work_dispatch.
module tb_work_dispatch;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;
    work_dispatch_if #(.CNT_W(16)) bus ();
    work_dispatch #(.START_GAP(2), .RX_TIMEOUT(20), .CNT_W(16)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [7:0] bytes_q [0:511];
    int start_cyc [0:511];
    int n = 0;
    int acc [0:15];
    int na = 0;
    int sent_p = 0, nv_p = 0, to_p = 0;
    logic busy_en = 1'b0;
    int bcnt = 0;
    // transmitter model: busy for 10 cycles after each start when enabled
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_start) bcnt <= 10;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign bus.tx_busy = busy_en && bcnt != 0;
    // accept edge is the posedge following the sampling negedge
    always @(negedge clk) begin
        if (bus.tx_start && n < 512) begin
            bytes_q[n]   <= bus.tx_data;
            start_cyc[n] <= cyc;
            n            <= n + 1;
        end
        if (bus.work_valid && bus.work_ready && na < 16) begin
            acc[na] <= cyc + 1;
            na      <= na + 1;
        end
        if (bus.work_sent)   sent_p <= sent_p + 1;
        if (bus.nonce_valid) nv_p   <= nv_p + 1;
        if (bus.rx_timeout)  to_p   <= to_p + 1;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data_ready = 1'b1;
        bus.rx_data       = b;
        tick();
        bus.rx_data_ready = 1'b0;
        repeat (gap) tick();
    endtask
    task automatic wait_sent(input int k, input int budget, input string tag);
        int seen = 0;
        int t = 0;
        while (seen < k && t < budget) begin
            tick();
            t++;
            if (bus.work_sent) begin
                seen++;
                if (seen == k) bus.work_valid = 1'b0;
            end
        end
        chk(tag, seen, k);
    endtask
    function automatic logic [7:0] pat(input int j);
        return j < 32 ? 8'(j) : 8'(8'h60 + j);
    endfunction
    function automatic logic [7:0] exp2(input int j);
        return j < 31 ? 8'h00 : j == 31 ? 8'h01 : j < 63 ? 8'hFF : 8'hFE;
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int b, a, s, nv, to, bad;
        reset_n = 1'b0;
        bus.work_valid = 1'b1;
        bus.midstate = '0;
        bus.data2 = '0;
        bus.rx_data_ready = 1'b0;
        bus.rx_data = '0;
        // reset with work offered
        tick();
        tick();
        chk("rst_work_ready", bus.work_ready, 0);
        chk("rst_tx_start", bus.tx_start, 0);
        reset_n = 1'b1;
        bus.work_valid = 1'b0;
        tick();
        chk("post_rst_work_ready", bus.work_ready, 1);
        chk("post_rst_sent_count", bus.sent_count, 0);
        chk("post_rst_nonce_count", bus.nonce_count, 0);
        chk("post_rst_nonce", bus.nonce, 0);
        chk("post_rst_tx_data", bus.tx_data, 0);
        // packet with busy transmitter, nonce DEADBEEF arriving meanwhile
        b = n; a = na;
        busy_en = 1'b1;
        bus.midstate = 256'h1;
        bus.data2 = {{31{8'hFF}}, 8'hFE};
        bus.work_valid = 1'b1;
        tick();
        bus.work_valid = 1'b0;
        chk("t2_busy_ready", bus.work_ready, 0);
        send_byte(8'hDE, 3);
        send_byte(8'hAD, 7);
        send_byte(8'hBE, 5);
        send_byte(8'hEF, 2);
        chk("t3_nonce", bus.nonce, 32'hDEADBEEF);
        chk("t3_nonce_count", bus.nonce_count, 1);
        wait_sent(1, 3000, "t2_done");
        repeat (3) tick();
        chk("t2_byte_count", n - b, 64);
        for (int j = 0; j < 64; j++) chk($sformatf("t2_byte%0d", j), bytes_q[b + j], exp2(j));
        chk("t2_latency", start_cyc[b] - acc[a], 3);
        chk("t2_sent_pulses", sent_p, 1);
        chk("t2_sent_count", bus.sent_count, 1);
        chk("t2_ready_back", bus.work_ready, 1);
        chk("t3_nv_pulses", nv_p, 1);
        chk("t3_no_timeout", to_p, 0);
        // timeout drops 12 34, then 56789ABC completes
        nv = nv_p; to = to_p;
        send_byte(8'h12, 0);
        send_byte(8'h34, 20);
        send_byte(8'h56, 1);
        send_byte(8'h78, 0);
        send_byte(8'h9A, 2);
        send_byte(8'hBC, 3);
        chk("t4_nonce", bus.nonce, 32'h56789ABC);
        chk("t4_nonce_count", bus.nonce_count, 2);
        chk("t4_timeout_pulses", to_p - to, 1);
        chk("t4_nv_pulses", nv_p - nv, 1);
        // two back-to-back packets, tx_busy never asserted
        busy_en = 1'b0;
        b = n; a = na; s = sent_p;
        for (int i = 0; i < 32; i++) begin
            bus.midstate[255 - 8*i -: 8] = pat(i);
            bus.data2[255 - 8*i -: 8]    = pat(32 + i);
        end
        bus.work_valid = 1'b1;
        wait_sent(2, 2000, "t5_done");
        repeat (3) tick();
        chk("t5_byte_count", n - b, 128);
        chk("t5_sent_pulses", sent_p - s, 2);
        chk("t5_sent_count", bus.sent_count, 3);
        bad = 0;
        for (int j = 0; j < 128; j++) if (bytes_q[b + j] !== pat(j % 64)) bad++;
        chk("t5_bytes", bad, 0);
        bad = 0;
        for (int p = 0; p < 2; p++)
            for (int j = 1; j < 64; j++)
                if (start_cyc[b + 64*p + j] - start_cyc[b + 64*p + j - 1] != 4) bad++;
        chk("t5_spacing", bad, 0);
        chk("t5_latency1", start_cyc[b] - acc[a], 3);
        chk("t5_latency2", start_cyc[b + 64] - acc[a + 1], 3);
        // reset at byte 30 abandons the packet
        b = n;
        bus.work_valid = 1'b1;
        for (int t = 0; t < 500 && n - b < 30; t++) tick();
        chk("t6_reached_30", n - b >= 30, 1);
        s = sent_p;
        reset_n = 1'b0;
        tick();
        tick();
        chk("t6_rst_ready", bus.work_ready, 0);
        chk("t6_rst_tx_start", bus.tx_start, 0);
        chk("t6_rst_sent_count", bus.sent_count, 0);
        chk("t6_rst_nonce", bus.nonce, 0);
        reset_n = 1'b1;
        b = n;
        tick();
        bus.work_valid = 1'b0;
        chk("t6_no_sent", sent_p - s, 0);
        chk("t6_sent_count0", bus.sent_count, 0);
        wait_sent(1, 1000, "t6_done");
        repeat (3) tick();
        chk("t6_byte_count", n - b, 64);
        chk("t6_first_byte", bytes_q[b], 8'h00);
        bad = 0;
        for (int j = 0; j < 64; j++) if (bytes_q[b + j] !== pat(j)) bad++;
        chk("t6_bytes", bad, 0);
        chk("t6_sent_count1", bus.sent_count, 1);
        chk("t6_ready", bus.work_ready, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
